// File: rtl/shift_reg_universal.sv
// Universal shift register: serial in/out, parallel load and rotate, with a
// frame counter that latches every completed WIDTH-bit serial word.
module shift_reg_universal #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_p,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic                     d,
   input  logic [WIDTH-1:0]         par_in,
   output logic                     f,
   output logic [WIDTH-1:0]         q,
   output logic [WIDTH-1:0]         frame_q,
   output logic                     frame_valid,
   output logic [$clog2(WIDTH):0]   bit_cnt
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ModeHold   = 2'b00,
      ModeShift  = 2'b01,
      ModeLoad   = 2'b10,
      ModeRotate = 2'b11
   } mode_e;

   mode_e            op;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] rotated;

   assign op = mode_e'(mode);

   // Bit order only changes which end is the input and which is the output.
   if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {d, q[WIDTH-1:1]};
      assign rotated = {q[0], q[WIDTH-1:1]};
      assign f       = q[0];
   end else begin : g_msb_first
      assign shifted = {q[WIDTH-2:0], d};
      assign rotated = {q[WIDTH-2:0], q[WIDTH-1]};
      assign f       = q[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         q           <= '0;
         frame_q     <= '0;
         frame_valid <= 1'b0;
         bit_cnt     <= '0;
      end else begin
         frame_valid <= 1'b0;
         if (en) begin
            case (op)
               ModeShift: begin
                  q <= shifted;
                  if (bit_cnt == LAST_BIT) begin
                     frame_q     <= shifted;
                     frame_valid <= 1'b1;
                     bit_cnt     <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               ModeLoad: begin
                  // A load discards any partially received frame.
                  q       <= par_in;
                  bit_cnt <= '0;
               end
               ModeRotate: q <= rotated;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register that replaces the fixed 8-bit SISO/SIPO blocks with one configurable unit. It supports serial-in, serial-out, parallel-load and rotate modes, with a selectable bit order. A frame counter latches each completed WIDTH-bit serial word and flags it with a one-cycle valid pulse. It sits between serial links (bit-banged or UART-like) and word-wide datapath logic, and serves as both the deserialiser and the serialiser.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- LSB_FIRST, 1, serial bit order.
  - 1: shift right; serial input enters bit WIDTH-1; serial output is bit 0.
  - 0: shift left; serial input enters bit 0; serial output is bit WIDTH-1.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset_p  input  1  synchronous, active-high reset.
- en  input  1  operation enable; when 0 the block holds all state.
- mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE.
- d  input  1  serial data in; sampled only in SHIFT.
- par_in  input  WIDTH  parallel load word; sampled only in LOAD.
- f  output  1  serial data out; equals the current output-end bit of q (no extra register stage).
- q  output  WIDTH  live shift register contents.
- frame_q  output  WIDTH  last completed serial frame.
- frame_valid  output  1  registered one-cycle pulse; frame_q was updated this cycle.
- bit_cnt  output  $clog2(WIDTH)+1  SHIFT operations since the last frame boundary, load or reset; range 0..WIDTH-1.

## Operation
- Reset (reset_p=1 at a clock edge): q, frame_q, bit_cnt and frame_valid all become 0; hence f=0. Reset has priority over en and mode.
- en=0: q, bit_cnt and frame_q hold; frame_valid=0.
- en=1, mode HOLD: same as en=0.
- en=1, mode SHIFT:
  - LSB_FIRST=1: q <= {d, q[WIDTH-1:1]}.
  - LSB_FIRST=0: q <= {q[WIDTH-2:0], d}.
  - If bit_cnt==WIDTH-1: frame_q <= the new q value, frame_valid <= 1, bit_cnt <= 0.
  - Otherwise: bit_cnt <= bit_cnt+1, frame_valid <= 0.
- en=1, mode LOAD: q <= par_in; bit_cnt <= 0 (any partial frame is discarded); frame_valid <= 0; frame_q holds.
- en=1, mode ROTATE: the output-end bit re-enters at the input end (rotate right when LSB_FIRST=1, rotate left otherwise); bit_cnt, frame_q hold; frame_valid <= 0.
- d is ignored in every mode except SHIFT. par_in is ignored in every mode except LOAD.
- Pausing with en=0 or HOLD in mid-frame preserves bit_cnt. The frame completes after WIDTH total SHIFT operations, whether contiguous or not.
- Reset in mid-frame discards the partial word. The next frame needs a full WIDTH shifts.

## Timing
- All outputs are registered, or derive combinationally from registers only (f). No input-to-output combinational path.
- SIPO latency: frame_valid and the new frame_q appear in the cycle after the edge that performs the WIDTH-th shift. frame_valid is high for exactly one cycle, unless the next frame also completes.
- PISO latency:
  - LOAD at edge N: f shows the first bit (par_in[0] when LSB_FIRST=1, else par_in[WIDTH-1]) during cycle N+1.
  - Each subsequent SHIFT edge presents the next bit.
- Simultaneous serial in and out: in SHIFT, f carries the old output-end bit up to the edge, while d enters on the same edge. Full duplex is supported.
- Frame completion and a pause cannot coincide: a completed shift always pulses frame_valid, independent of the next cycle's en or mode.
- A continuous SHIFT stream gives one frame_valid every WIDTH cycles, with no dead cycle.

## Test plan
- SIPO, LSB_FIRST=1, WIDTH=8: reset 1 cycle, then en=1, mode=01, d=bit i of 0xBC for i=0..7, one per cycle.
  - Required: q=0xBC, frame_q=0xBC, frame_valid=1 for exactly one cycle, bit_cnt=0.
- PISO: LOAD par_in=0xBC, then 8× SHIFT with d=0.
  - Required: f sequence 0,0,1,1,1,1,0,1; final q=0x00.
  - Required: a frame_valid pulse with frame_q=0x00 (the shifted-in zeros complete a frame).
- ROTATE: LOAD 0xBC, then ROTATE.
  - Required: after 1 rotate q=0x5E; after 8 rotates q=0xBC.
  - Required: frame_valid stays 0 and bit_cnt stays 0 throughout.
- Pause/resume: 4 SHIFTs of 0xBC bits 0..3, then en=0 for 5 cycles (bit_cnt holds at 4), then bits 4..7.
  - Required: frame_valid after the 8th shift with frame_q=0xBC.
- Reset and LOAD in mid-frame:
  - 5 SHIFTs, then reset_p=1 for one cycle: all outputs 0. A following 8-bit 0xBC stream yields frame_q=0xBC.
  - Repeat with LOAD 0x00 in place of the reset: bit_cnt=0, and the following 0xBC stream still yields frame_q=0xBC.
- MSB-first, LSB_FIRST=0, WIDTH=16: shift in 0xA5C3 starting from bit 15.
  - Required: frame_q=0xA5C3.
  - Required: a LOAD of 0xA5C3 followed by shifts gives an f sequence starting 1,0,1,0.
